// File: rtl/fazyrv_alu_pkg.sv
// Shared types for the chunk-serial ALU: opcode and sequencer state encodings,
// plus the opcode decode helpers used by both the datapath and the sequencer.
package fazyrv_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_EQ  = 3'd5,
        ALU_LT  = 3'd6,
        ALU_LTU = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Compares run through the adder as a subtraction, so they invert b too.
    function automatic logic op_is_sub(alu_op_t op);
        return op inside {ALU_SUB, ALU_EQ, ALU_LT, ALU_LTU};
    endfunction

    function automatic logic op_is_cmp(alu_op_t op);
        return op inside {ALU_EQ, ALU_LT, ALU_LTU};
    endfunction

endpackage

// File: rtl/fazyrv_alu_seq_if.sv
// Operand/result stream interface of the chunk-serial ALU. The ovf_o signal
// exists only when FAZYRV_ALU_OVF_EN is defined.
interface fazyrv_alu_seq_if
    import fazyrv_alu_pkg::*;
#(
    parameter int BWIDTH = 4
);
    logic              start_i;
    alu_op_t           op_i;
    logic              stall_i;
    logic              flush_i;
    logic [BWIDTH-1:0] a_i;
    logic [BWIDTH-1:0] b_i;
    logic [BWIDTH-1:0] res_o;
    logic              res_vld_o;
    logic              lsb_o;
    logic              msb_o;
    logic              busy_o;
    logic              done_o;
    logic              cmp_o;
`ifdef FAZYRV_ALU_OVF_EN
    logic              ovf_o;
`endif

    modport master (
`ifdef FAZYRV_ALU_OVF_EN
        input  ovf_o,
`endif
        output start_i, op_i, stall_i, flush_i, a_i, b_i,
        input  res_o, res_vld_o, lsb_o, msb_o, busy_o, done_o, cmp_o
    );

    modport slave (
`ifdef FAZYRV_ALU_OVF_EN
        output ovf_o,
`endif
        input  start_i, op_i, stall_i, flush_i, a_i, b_i,
        output res_o, res_vld_o, lsb_o, msb_o, busy_o, done_o, cmp_o
    );

endinterface

// File: rtl/fazyrv_alu_chunk.sv
// Combinational BWIDTH-bit slice of the serial ALU: adder, bitwise logic and
// chunk magnitude compare. Carry into the MSB is exported under FAZYRV_ALU_OVF_EN.
module fazyrv_alu_chunk
    import fazyrv_alu_pkg::*;
#(
    parameter int BWIDTH = 4
) (
    input  alu_op_t           op_i,
    input  logic [BWIDTH-1:0] a_i,
    input  logic [BWIDTH-1:0] b_i,
    input  logic              cin_i,
    input  logic              msb_i,
    output logic [BWIDTH-1:0] res_o,
    output logic              cout_o,
`ifdef FAZYRV_ALU_OVF_EN
    output logic              msb_cin_o,
`endif
    output logic              lo_o,
    output logic              gr_o
);

    logic              sub;
    logic [BWIDTH-1:0] b_eff;
    logic [BWIDTH-1:0] sum;
    logic [BWIDTH-1:0] sgn;
    logic [BWIDTH-1:0] a_cmp;
    logic [BWIDTH-1:0] b_cmp;

    always_comb begin
        sub           = op_is_sub(op_i);
        b_eff         = b_i ^ {BWIDTH{sub}};
        {cout_o, sum} = {1'b0, a_i} + {1'b0, b_eff} + {{BWIDTH{1'b0}}, cin_i};

        // Signed compare only differs from unsigned in the top chunk's sign bits.
        sgn             = '0;
        sgn[BWIDTH-1]   = msb_i && (op_i == ALU_LT);
        a_cmp           = a_i ^ sgn;
        b_cmp           = b_i ^ sgn;
        lo_o            = a_cmp < b_cmp;
        gr_o            = a_cmp > b_cmp;

        unique case (op_i)
            ALU_AND: res_o = a_i & b_i;
            ALU_XOR: res_o = a_i ^ b_i;
            ALU_OR:  res_o = a_i | b_i;
            default: res_o = sum;
        endcase
    end

`ifdef FAZYRV_ALU_OVF_EN
    assign msb_cin_o = sum[BWIDTH-1] ^ a_i[BWIDTH-1] ^ b_eff[BWIDTH-1];
`endif

endmodule

// File: rtl/fazyrv_alu_seq.sv
// Self-sequenced chunk-serial ALU: consumes XLEN-bit operands BWIDTH bits per
// cycle, LSB chunk first. Define FAZYRV_ALU_OVF_EN to add the ovf_o flag.
module fazyrv_alu_seq
    import fazyrv_alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int BWIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_in,
    fazyrv_alu_seq_if.slave  bus
);

    localparam int CHUNKS = XLEN / BWIDTH;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

    if (XLEN % BWIDTH != 0) begin : g_bad_cfg
        $error("fazyrv_alu_seq: XLEN must be a multiple of BWIDTH");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cmp_q, cmp_d;
    alu_op_t           op_q, op_d;
`ifdef FAZYRV_ALU_OVF_EN
    logic              ovf_q, ovf_d;
    logic              msb_cin;
`endif

    logic              run, lsb, msb, take;
    logic [BWIDTH-1:0] res_c;
    logic              cout, lo, gr;

    assign run  = (state_q == RUN);
    assign lsb  = run && (cnt_q == '0);
    assign msb  = run && (cnt_q == LAST);
    assign take = run && !bus.stall_i && !bus.flush_i;

    fazyrv_alu_chunk #(.BWIDTH(BWIDTH)) u_chunk (
        .op_i      (op_q),
        .a_i       (bus.a_i),
        .b_i       (bus.b_i),
        .cin_i     (lsb ? op_is_sub(op_q) : carry_q),
        .msb_i     (msb),
        .res_o     (res_c),
        .cout_o    (cout),
`ifdef FAZYRV_ALU_OVF_EN
        .msb_cin_o (msb_cin),
`endif
        .lo_o      (lo),
        .gr_o      (gr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmp_d   = cmp_q;
        op_d    = op_q;
`ifdef FAZYRV_ALU_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (bus.flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start_i) begin
                    state_d = RUN;
                    op_d    = bus.op_i;
                    cnt_d   = '0;
`ifdef FAZYRV_ALU_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
                RUN: if (!bus.stall_i) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    carry_d = cout;
                    // Chunks arrive LSB first, so a decisive higher chunk overrides.
                    if (op_q == ALU_EQ) begin
                        cmp_d = (lsb | cmp_q) & (bus.a_i == bus.b_i);
                    end else if (op_q inside {ALU_LT, ALU_LTU}) begin
                        if (lo)       cmp_d = 1'b1;
                        else if (gr)  cmp_d = 1'b0;
                        else if (lsb) cmp_d = 1'b0;
                    end
`ifdef FAZYRV_ALU_OVF_EN
                    if (msb && (op_q inside {ALU_ADD, ALU_SUB})) ovf_d = msb_cin ^ cout;
`endif
                    if (msb) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmp_q   <= 1'b0;
            op_q    <= ALU_ADD;
`ifdef FAZYRV_ALU_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmp_q   <= cmp_d;
            op_q    <= op_d;
`ifdef FAZYRV_ALU_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.res_o     = run ? res_c : '0;
    assign bus.res_vld_o = take;
    assign bus.lsb_o     = lsb;
    assign bus.msb_o     = msb;
    assign bus.busy_o    = run;
    assign bus.done_o    = (state_q == DONE);
    assign bus.cmp_o     = cmp_q;
`ifdef FAZYRV_ALU_OVF_EN
    assign bus.ovf_o     = ovf_q;
`endif

endmodule

// File: tb/tb_fazyrv_alu_seq.sv
// Scoreboard bench for fazyrv_alu_seq (XLEN=32, BWIDTH=4): whole-word reference
// model, directed corner cases, then randomized ops with stalls and flushes.
module tb_fazyrv_alu_seq;
    import fazyrv_alu_pkg::*;

    localparam int XLEN   = 32;
    localparam int BW     = 4;
    localparam int CHUNKS = XLEN / BW;

    logic clk_i  = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_i = ~clk_i;

    fazyrv_alu_seq_if #(.BWIDTH(BW)) bus ();

    fazyrv_alu_seq #(.XLEN(XLEN), .BWIDTH(BW)) dut (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct {
        logic [BW-1:0] res;
        int            idx;
    } chunk_t;

    typedef struct {
        logic cmp;
        logic ovf;
    } fin_t;

    chunk_t exp_q[$];
    fin_t   fin_q[$];
    int     n_chk = 0;
    int     n_pass = 0;
    logic   model_cmp = 1'b0;
    logic   model_ovf = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic void fail(string name, int act, int exp);
        n_chk++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic logic [31:0] ref_res(alu_op_t op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return a - b;
        endcase
    endfunction

    function automatic logic ref_cmp(alu_op_t op, logic [31:0] a, logic [31:0] b, logic prior);
        case (op)
            ALU_EQ:  return a == b;
            ALU_LT:  return $signed(a) < $signed(b);
            ALU_LTU: return a < b;
            default: return prior;
        endcase
    endfunction

    function automatic logic ref_ovf(alu_op_t op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        r = ref_res(op, a, b);
        if (op == ALU_ADD) return (a[31] == b[31]) && (r[31] != a[31]);
        if (op == ALU_SUB) return (a[31] != b[31]) && (r[31] != a[31]);
        return 1'b0;
    endfunction

    // Compare state after only the k low chunks have been consumed.
    function automatic logic part_cmp(alu_op_t op, logic [31:0] a, logic [31:0] b, int k, logic prior);
        logic [63:0] m, al, bl;
        if (k == 0 || !op_is_cmp(op)) return prior;
        m  = (64'd1 << (BW * k)) - 64'd1;
        al = {32'b0, a} & m;
        bl = {32'b0, b} & m;
        if (op == ALU_EQ) return al == bl;
        return al < bl;
    endfunction

    initial begin : monitor
        chunk_t e;
        fin_t   f;
        forever begin
            @(negedge clk_i);
            if (rst_in) begin
                if (bus.res_vld_o) begin
                    if (exp_q.size() == 0) fail("vld_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("res_chunk", 32'(bus.res_o), 32'(e.res));
                        check("lsb", 32'(bus.lsb_o), 32'(e.idx == 0));
                        check("msb", 32'(bus.msb_o), 32'(e.idx == CHUNKS - 1));
                    end
                end
                if (bus.done_o) begin
                    if (fin_q.size() == 0) fail("done_unexpected", 1, 0);
                    else begin
                        f = fin_q.pop_front();
                        check("cmp", 32'(bus.cmp_o), 32'(f.cmp));
`ifdef FAZYRV_ALU_OVF_EN
                        check("ovf", 32'(bus.ovf_o), 32'(f.ovf));
`endif
                    end
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic run_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [CHUNKS-1:0] stall_mask, input int flush_at, input bit spam);
        logic [31:0]       r;
        logic [CHUNKS-1:0] pend;
        int                k;
        r    = ref_res(op, a, b);
        pend = stall_mask;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        @(posedge clk_i); #1;
        bus.start_i = spam;
        if (spam) bus.op_i = ALU_XOR;
        k = 0;
        while (k < CHUNKS) begin
            bus.a_i = a[k*BW +: BW];
            bus.b_i = b[k*BW +: BW];
            if (k == flush_at) begin
                bus.flush_i = 1'b1;
                bus.stall_i = 1'($urandom_range(0, 1));
            end else if (pend[k]) begin
                bus.stall_i = 1'b1;
                pend[k]     = 1'b0;
            end else begin
                bus.stall_i = 1'b0;
                exp_q.push_back(chunk_t'{r[k*BW +: BW], k});
            end
            @(posedge clk_i); #1;
            if (bus.flush_i) begin
                bus.flush_i = 1'b0;
                bus.stall_i = 1'b0;
                bus.start_i = 1'b0;
                model_cmp   = part_cmp(op, a, b, k, model_cmp);
                model_ovf   = 1'b0;
                check("flush_idle", 32'(bus.busy_o), 32'd0);
                check("flush_cmp", 32'(bus.cmp_o), 32'(model_cmp));
                @(posedge clk_i); #1;
                check("flush_no_done", 32'(bus.done_o), 32'd0);
                return;
            end
            if (!bus.stall_i) k++;
            if (k < CHUNKS) check("busy_run", 32'(bus.busy_o), 32'd1);
        end
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
        model_cmp   = ref_cmp(op, a, b, model_cmp);
        model_ovf   = ref_ovf(op, a, b);
        fin_q.push_back(fin_t'{model_cmp, model_ovf});
        check("done_pulse", 32'(bus.done_o), 32'd1);
        @(posedge clk_i); #1;
        check("done_one_cycle", 32'(bus.done_o), 32'd0);
    endtask

    initial begin : driver
        bus.start_i = 1'b0;
        bus.op_i    = ALU_ADD;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.a_i     = 4'hF;
        bus.b_i     = 4'hF;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_vld", 32'(bus.res_vld_o), 32'd0);
        check("rst_res", 32'(bus.res_o), 32'd0);
        check("rst_lsb_msb", 32'({bus.lsb_o, bus.msb_o}), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_cmp", 32'(bus.cmp_o), 32'd0);
        rst_in = 1'b1;
        @(posedge clk_i); #1;

        run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, '0, -1, 1'b0);
        run_op(ALU_SUB, 32'd5, 32'd7, '0, -1, 1'b0);
        run_op(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, '0, -1, 1'b0);
        run_op(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, '0, -1, 1'b0);
        run_op(ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, '0, -1, 1'b0);
        run_op(ALU_LT,  32'hFFFF_FFFF, 32'h0000_0001, '0, -1, 1'b0);
        run_op(ALU_LTU, 32'hFFFF_FFFF, 32'h0000_0001, '0, -1, 1'b0);
        run_op(ALU_EQ,  32'h1234_5678, 32'h1234_5678, '0, -1, 1'b0);
        run_op(ALU_EQ,  32'h1234_5678, 32'h1234_5679, '0, -1, 1'b0);
        run_op(ALU_ADD, 32'h89AB_CDEF, 32'h7654_3211, 8'b0010_0100, -1, 1'b0);
        run_op(ALU_LT,  32'h8000_1234, 32'h0000_1234, '0, 4, 1'b0);
        run_op(ALU_ADD, 32'h0000_000F, 32'h0000_0001, '0, -1, 1'b0);
        run_op(ALU_ADD, 32'h1234_5678, 32'h0F0F_0F0F, '0, -1, 1'b1);
        run_op(ALU_SUB, 32'h8000_0000, 32'h0000_0001, 8'b1000_0001, -1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            alu_op_t     op;
            logic [31:0] a, b;
            int          fl;
            op = alu_op_t'(3'($urandom_range(0, 7)));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, CHUNKS - 1)) : -1;
            run_op(op, a, b, 8'($urandom) & 8'($urandom), fl, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of an op.
        run_op(ALU_EQ, 32'hCAFE_F00D, 32'hCAFE_F00D, '0, -1, 1'b0);
        bus.start_i = 1'b1;
        bus.op_i    = ALU_SUB;
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.a_i = 4'h9;
            bus.b_i = 4'h2;
            exp_q.push_back(chunk_t'{4'h7, k});
            @(posedge clk_i); #1;
        end
        #1;
        rst_in = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy_o), 32'd0);
        check("arst_vld", 32'(bus.res_vld_o), 32'd0);
        check("arst_res", 32'(bus.res_o), 32'd0);
        check("arst_lsb_msb", 32'({bus.lsb_o, bus.msb_o}), 32'd0);
        check("arst_done", 32'(bus.done_o), 32'd0);
        check("arst_cmp", 32'(bus.cmp_o), 32'd0);
        exp_q.delete();
        fin_q.delete();
        model_cmp = 1'b0;
        model_ovf = 1'b0;
        rst_in    = 1'b1;
        @(posedge clk_i); #1;
        run_op(ALU_SUB, 32'h0000_0000, 32'h0000_0001, '0, -1, 1'b0);

        for (int i = 0; i < 20 && (exp_q.size() + fin_q.size()) != 0; i++) @(posedge clk_i);
        #1;
        check("drain", 32'(exp_q.size() + fin_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
